rvcpu_lsu: RTL and testbench



---
 rtl/rvcpu_lsu_pkg.sv | 72 +++++++
 rtl/rvcpu_lsu_align.sv | 33 +++
 rtl/rvcpu_lsu.sv | 236 +++++++++++++++++++++++
 tb/tb_rvcpu_lsu.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_lsu_pkg.sv
// Shared definitions for the rvcpu load/store unit.
//   - RV32 load/store funct3 encodings
//   - LSU state encoding
//   - byte-mask / lane helpers used by the LSU and its aligner
package rvcpu_lsu_pkg;

  // RV32 width/sign encodings carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACC_LO  = 3'd1,
    ST_ACC_HI  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_ERR     = 3'd4
  } lsu_state_e;

  // Access size in bytes (1/2/4); illegal encodings are caught elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] sz;
    case (funct3)
      F3_B, F3_BU: sz = 3'd1;
      F3_H, F3_HU: sz = 3'd2;
      default:     sz = 3'd4;
    endcase
    return sz;
  endfunction

  // Two-word byte mask: bits [3:0] are lanes of the addressed word,
  // bits [7:4] the lanes spilling into the next word.
  function automatic logic [7:0] byte_mask2(input logic [2:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      3'd4:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Byte mask within the addressed word only.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
    logic [7:0] m;
    m = byte_mask2(size, off);
    return m[3:0];
  endfunction

  // Access crosses into the next word iff off + size > 4.
  function automatic logic crosses(input logic [2:0] size, input logic [1:0] off);
    return ({1'b0, off} + size) > 3'd4;
  endfunction

  // Right-justified store data moved to its byte lanes across two words.
  function automatic logic [63:0] lane_shift(input logic [31:0] w, input logic [1:0] off);
    return {32'h0000_0000, w} << {off, 3'b000};
  endfunction

  // Zero the lanes that are not being written so dmem_d is clean.
  function automatic logic [31:0] lane_keep(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? d[8*b +: 8] : 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/rvcpu_lsu_align.sv
// Load-data aligner (purely combinational).
//   q_pair_i  : {q_hi, q_lo} words read from dmem (q_hi = 0 when not split)
//   off_i     : byte offset of the access within q_lo
//   funct3_i  : RV32 width/sign encoding
//   rdata_o   : selected bytes, sign- or zero-extended to 32 bits
module rvcpu_lsu_align
  import rvcpu_lsu_pkg::*;
(
  input  logic [63:0] q_pair_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [31:0] span_s;

  // Bring the first addressed byte down to lane 0; upper bits are discarded.
  assign span_s = 32'(q_pair_i >> {off_i, 3'b000});

  // Width selection and extension
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    rdata_o = {{24{span_s[7]}}, span_s[7:0]};
      F3_H:    rdata_o = {{16{span_s[15]}}, span_s[15:0]};
      F3_W:    rdata_o = span_s;
      F3_BU:   rdata_o = {24'h00_0000, span_s[7:0]};
      F3_HU:   rdata_o = {16'h0000, span_s[15:0]};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rvcpu_lsu.sv
// rvcpu load/store unit: one request at a time towards a word-addressed,
// byte-enabled dmem with one-cycle registered read.
//   req_*   : request from execute (valid/ready handshake, ready only in IDLE)
//   resp_*  : one-cycle completion pulse with extended load data / error flag
//   dmem_*  : registered dmem strobe, word address, lane data, byte enables;
//             dmem_q_i is valid the cycle after dmem_en_o
// Word-crossing accesses are issued as two consecutive dmem accesses when
// SPLIT_EN=1, otherwise they complete with resp_err_o.
module rvcpu_lsu
  import rvcpu_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter bit SPLIT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        dmem_en_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_d_o,
  output logic [3:0]  dmem_we_o,
  input  logic [31:0] dmem_q_i
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  lsu_state_e  state_q, state_d;

  // Request context latched at acceptance
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] word_q, word_d;
  logic        cross_q, cross_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wd_hi_q, wd_hi_d;
  logic [31:0] q_lo_q, q_lo_d;

  // Registered outputs
  logic        dmem_en_q, dmem_en_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_d_q, dmem_d_d;
  logic [3:0]  dmem_we_q, dmem_we_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Request decode
  logic [1:0]  req_off_s;
  logic [29:0] req_word_s;
  logic [2:0]  req_size_s;
  logic        req_cross_s;
  logic [7:0]  req_mask8_s;
  logic [63:0] req_lanes_s;
  logic [30:0] req_hi_word_s;
  logic        req_f3_ok_s;
  logic        req_range_err_s;
  logic        req_err_s;
  logic [63:0] q_pair_s;
  logic [31:0] align_rdata_s;

  assign req_off_s     = req_addr_i[1:0];
  assign req_word_s    = req_addr_i[31:2];
  assign req_size_s    = access_size(req_funct3_i);
  assign req_cross_s   = crosses(req_size_s, req_off_s);
  assign req_mask8_s   = byte_mask2(req_size_s, req_off_s);
  assign req_lanes_s   = lane_shift(req_wdata_i, req_off_s);
  // One extra bit so a high word past 0x3FFF_FFFF is seen as out of range
  assign req_hi_word_s = {1'b0, req_word_s} + 31'd1;

  // Legal funct3: stores have no unsigned variants
  always_comb begin
    req_f3_ok_s = 1'b0;
    case (req_funct3_i)
      F3_B, F3_H, F3_W: req_f3_ok_s = 1'b1;
      F3_BU, F3_HU:     req_f3_ok_s = ~req_store_i;
      default:          req_f3_ok_s = 1'b0;
    endcase
  end

  assign req_range_err_s = ({2'b00, req_word_s} >= DEPTH_L) ||
                           (req_cross_s && (req_hi_word_s[30] ||
                                            ({1'b0, req_hi_word_s} >= DEPTH_L)));

  assign req_err_s = ~req_f3_ok_s || req_range_err_s || (req_cross_s && !SPLIT_EN);

  assign req_ready_o = (state_q == ST_IDLE) && rst_n;

  // Non-split loads see only one word; q_hi is zero so nothing leaks in
  assign q_pair_s = cross_q ? {dmem_q_i, q_lo_q} : {32'h0000_0000, dmem_q_i};

  rvcpu_lsu_align u_align (
    .q_pair_i (q_pair_s),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .rdata_o  (align_rdata_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    word_d       = word_q;
    cross_d      = cross_q;
    be_hi_d      = be_hi_q;
    wd_hi_d      = wd_hi_q;
    q_lo_d       = q_lo_q;
    dmem_en_d    = 1'b0;
    dmem_addr_d  = 32'h0000_0000;
    dmem_d_d     = 32'h0000_0000;
    dmem_we_d    = 4'h0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          store_d  = req_store_i;
          funct3_d = req_funct3_i;
          off_d    = req_off_s;
          word_d   = req_word_s;
          cross_d  = req_cross_s;
          // High-word store lanes are prepared now; inputs may change later
          be_hi_d  = req_store_i ? req_mask8_s[7:4] : 4'h0;
          wd_hi_d  = req_store_i ? lane_keep(req_lanes_s[63:32], req_mask8_s[7:4])
                                 : 32'h0000_0000;
          if (req_err_s) begin
            state_d = ST_ERR;
          end else begin
            state_d     = ST_ACC_LO;
            dmem_en_d   = 1'b1;
            dmem_addr_d = {2'b00, req_word_s};
            dmem_we_d   = req_store_i ? req_mask8_s[3:0] : 4'h0;
            dmem_d_d    = req_store_i ? lane_keep(req_lanes_s[31:0], req_mask8_s[3:0])
                                      : 32'h0000_0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACC_LO: begin
        if (cross_q) begin
          state_d     = ST_ACC_HI;
          dmem_en_d   = 1'b1;
          dmem_addr_d = {2'b00, word_q} + 32'd1;
          dmem_we_d   = be_hi_q;
          dmem_d_d    = wd_hi_q;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_ACC_HI: begin
        // Low word read data arrives now
        q_lo_d  = dmem_q_i;
        state_d = ST_COLLECT;
      end

      ST_COLLECT: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = store_q ? 32'h0000_0000 : align_rdata_s;
      end

      ST_ERR: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      word_q       <= 30'h0000_0000;
      cross_q      <= 1'b0;
      be_hi_q      <= 4'h0;
      wd_hi_q      <= 32'h0000_0000;
      q_lo_q       <= 32'h0000_0000;
      dmem_en_q    <= 1'b0;
      dmem_addr_q  <= 32'h0000_0000;
      dmem_d_q     <= 32'h0000_0000;
      dmem_we_q    <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      word_q       <= word_d;
      cross_q      <= cross_d;
      be_hi_q      <= be_hi_d;
      wd_hi_q      <= wd_hi_d;
      q_lo_q       <= q_lo_d;
      dmem_en_q    <= dmem_en_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_d_q     <= dmem_d_d;
      dmem_we_q    <= dmem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign dmem_en_o    = dmem_en_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_d_o     = dmem_d_q;
  assign dmem_we_o    = dmem_we_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_rvcpu_lsu.sv
// Self-checking bench for rvcpu_lsu: directed steps from the test plan plus
// randomized traffic against a byte-level memory reference model.
module tb_rvcpu_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dmem_en;
  logic [31:0] dmem_addr, dmem_d;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_q = 32'h0;

  // Second instance with splitting disabled; its dmem always returns zero
  logic        ns_req_valid = 1'b0;
  logic [2:0]  ns_req_funct3 = 3'b000;
  logic [31:0] ns_req_addr = 32'h0;
  logic        ns_req_ready, ns_resp_valid, ns_resp_err, ns_dmem_en;
  logic [31:0] ns_resp_rdata, ns_dmem_addr, ns_dmem_d;
  logic [3:0]  ns_dmem_we;
  logic        ns_req_store = 1'b0;
  logic [31:0] ns_req_wdata = 32'h0;
  logic [31:0] ns_dmem_q = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvcpu_lsu #(.DEPTH_WORDS(4096), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .dmem_en_o(dmem_en), .dmem_addr_o(dmem_addr), .dmem_d_o(dmem_d),
    .dmem_we_o(dmem_we), .dmem_q_i(dmem_q)
  );

  rvcpu_lsu #(.DEPTH_WORDS(4096), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(ns_req_valid), .req_ready_o(ns_req_ready), .req_store_i(ns_req_store),
    .req_funct3_i(ns_req_funct3), .req_addr_i(ns_req_addr), .req_wdata_i(ns_req_wdata),
    .resp_valid_o(ns_resp_valid), .resp_rdata_o(ns_resp_rdata), .resp_err_o(ns_resp_err),
    .dmem_en_o(ns_dmem_en), .dmem_addr_o(ns_dmem_addr), .dmem_d_o(ns_dmem_d),
    .dmem_we_o(ns_dmem_we), .dmem_q_i(ns_dmem_q)
  );

  // dmem: word array, byte enables, one-cycle registered read
  logic [31:0] mem [0:4095];
  logic        clr = 1'b1;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else if (dmem_en) begin
      if (dmem_addr < 32'd4096) begin
        dmem_q <= mem[dmem_addr[11:0]];
        for (int b = 0; b < 4; b++)
          if (dmem_we[b]) mem[dmem_addr[11:0]][8*b +: 8] <= dmem_d[8*b +: 8];
      end else begin
        dmem_q <= 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: flat byte memory, little-endian
  logic [7:0] ref_b [0:16383];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int f3_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit f3_legal(input bit st, input logic [2:0] f3);
    return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
           (!st && (f3 == 3'b100 || f3 == 3'b101));
  endfunction

  // Expected outcome of one request; stores update the reference memory
  task automatic ref_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] e_rdata,
                            output logic e_err, output int e_lat, output int e_en);
    int sz;
    longint a;
    logic [31:0] v;
    sz = f3_size(f3);
    a = longint'(addr);
    e_err = !f3_legal(st, f3) || (a + sz - 1 >= 16384);
    e_rdata = 32'h0;
    if (e_err) begin
      e_lat = 2; e_en = 0;
    end else begin
      if ((addr % 4) + sz > 4) begin e_lat = 4; e_en = 2; end
      else begin e_lat = 3; e_en = 1; end
      v = 32'h0;
      for (int i = 0; i < sz; i++) begin
        if (st) ref_b[int'(a) + i] = wdata[8*i +: 8];
        else v[8*i +: 8] = ref_b[int'(a) + i];
      end
      if (!st) begin
        case (f3)
          3'b000:  e_rdata = {{24{v[7]}}, v[7:0]};
          3'b001:  e_rdata = {{16{v[15]}}, v[15:0]};
          default: e_rdata = v;
        endcase
      end
    end
  endtask

  // Results of the last transaction
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat, got_en;
  logic [31:0] rec_addr [2];
  logic [31:0] rec_d [2];
  logic [3:0]  rec_we [2];

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
    @(posedge clk);
    got_lat = 0; got_en = 0; got_rdata = 32'hX; got_err = 1'bX;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      end
      if (dmem_en) got_en++;
      if (k <= 2) begin
        rec_addr[k-1] = dmem_addr; rec_d[k-1] = dmem_d; rec_we[k-1] = dmem_we;
      end
      if (resp_valid) begin
        got_lat = k; got_rdata = resp_rdata; got_err = resp_err;
        break;
      end
    end
  endtask

  task automatic check_txn(input string name, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] e_rdata;
    logic e_err;
    int e_lat, e_en;
    ref_access(st, f3, addr, wdata, e_rdata, e_err, e_lat, e_en);
    do_txn(st, f3, addr, wdata);
    check({name, ".lat"}, 32'(got_lat), 32'(e_lat));
    check({name, ".err"}, {31'h0, got_err}, {31'h0, e_err});
    check({name, ".rdata"}, got_rdata, e_rdata);
    check({name, ".en"}, 32'(got_en), 32'(e_en));
  endtask

  task automatic ns_txn(input string name, input logic [2:0] f3, input logic [31:0] addr,
                        input logic e_err, input int e_lat, input int e_en);
    int lat, en;
    logic err;
    @(negedge clk);
    ns_req_funct3 = f3; ns_req_addr = addr; ns_req_valid = 1'b1;
    @(posedge clk);
    lat = 0; en = 0; err = 1'bX;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) ns_req_valid = 1'b0;
      if (ns_dmem_en) en++;
      if (ns_resp_valid) begin lat = k; err = ns_resp_err; break; end
    end
    check({name, ".lat"}, 32'(lat), 32'(e_lat));
    check({name, ".err"}, {31'h0, err}, {31'h0, e_err});
    check({name, ".en"}, 32'(en), 32'(e_en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp [3];
    int acc_c [3];
    int rsp_c [3];
    int idx, nr, e_lat, e_en;
    logic e_err;
    logic [2:0] f3_tab [5];
    bit st;
    logic [2:0] f3;
    logic [31:0] addr;

    for (int i = 0; i < 16384; i++) ref_b[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.dmem_en", {31'h0, dmem_en}, 32'h0);
    check("rst.dmem_we", {28'h0, dmem_we}, 32'h0);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.req_ready", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b1; clr = 1'b0;
    #1;
    check("rst.ready_after", {31'h0, req_ready}, 32'h1);

    // Preloads
    check_txn("pre.w5", 1'b1, 3'b010, 32'h14, 32'h80FF_7F01);
    check_txn("pre.w8", 1'b1, 3'b010, 32'h20, 32'h1234_5678);

    // Byte loads from word 5
    check_txn("lb14", 1'b0, 3'b000, 32'h14, 32'h0);
    check("lb14.val", got_rdata, 32'h0000_0001);
    check("lb14.addr", rec_addr[0], 32'd5);
    check("lb14.we", {28'h0, rec_we[0]}, 32'h0);
    check("lb14.d", rec_d[0], 32'h0);
    check_txn("lb17", 1'b0, 3'b000, 32'h17, 32'h0);
    check("lb17.val", got_rdata, 32'hFFFF_FF80);
    check_txn("lbu15", 1'b0, 3'b100, 32'h15, 32'h0);
    check("lbu15.val", got_rdata, 32'h0000_007F);

    // Halfword store into upper half of word 8
    check_txn("sh22", 1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
    check("sh22.addr", rec_addr[0], 32'd8);
    check("sh22.we", {28'h0, rec_we[0]}, 32'hC);
    check("sh22.d", rec_d[0], 32'hBEEF_0000);
    check_txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0);
    check("lw20.val", got_rdata, 32'hBEEF_5678);

    // Word-crossing store and load
    check_txn("sw1d", 1'b1, 3'b010, 32'h1D, 32'h1122_3344);
    check("sw1d.addr0", rec_addr[0], 32'd7);
    check("sw1d.we0", {28'h0, rec_we[0]}, 32'hE);
    check("sw1d.d0", rec_d[0], 32'h2233_4400);
    check("sw1d.addr1", rec_addr[1], 32'd8);
    check("sw1d.we1", {28'h0, rec_we[1]}, 32'h1);
    check("sw1d.d1", rec_d[1], 32'h0000_0011);
    check_txn("lw1d", 1'b0, 3'b010, 32'h1D, 32'h0);
    check("lw1d.val", got_rdata, 32'h1122_3344);

    // Errors and the top edge of memory
    check_txn("e.f3_011", 1'b0, 3'b011, 32'h0, 32'h0);
    check_txn("e.sbu", 1'b1, 3'b100, 32'h4, 32'h55);
    check_txn("e.range", 1'b0, 3'b010, 32'h4000, 32'h0);
    check_txn("e.cross_top", 1'b0, 3'b010, 32'h3FFD, 32'h0);
    check_txn("top.lb", 1'b0, 3'b000, 32'h3FFF, 32'h0);
    check_txn("e.wrap", 1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0);

    // Back-to-back aligned loads with req_valid held high
    b2b_addr[0] = 32'h14; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h1C;
    for (int i = 0; i < 3; i++) ref_access(1'b0, 3'b010, b2b_addr[i], 32'h0, b2b_exp[i], e_err, e_lat, e_en);
    idx = 0; nr = 0;
    acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0; rsp_c[0] = 0; rsp_c[1] = 0; rsp_c[2] = 0;
    @(negedge clk);
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = b2b_addr[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (resp_valid) begin
        if (nr < 3) begin
          rsp_c[nr] = cyc;
          check("b2b.rdata", resp_rdata, b2b_exp[nr]);
        end
        nr++;
      end
      if (req_ready && req_valid) begin
        acc_c[idx] = cyc;
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) req_addr = b2b_addr[idx];
        else req_valid = 1'b0;
      end
    end
    check("b2b.accepts", 32'(idx), 32'd3);
    check("b2b.resps", 32'(nr), 32'd3);
    check("b2b.gap1", 32'(acc_c[1] - acc_c[0]), 32'd3);
    check("b2b.gap2", 32'(acc_c[2] - acc_c[1]), 32'd3);
    for (int i = 0; i < 3; i++) check("b2b.lat", 32'(rsp_c[i] - acc_c[i]), 32'd3);

    // Splitting disabled
    ns_txn("ns.lw1", 3'b010, 32'h1, 1'b1, 2, 0);
    ns_txn("ns.lh1", 3'b001, 32'h1, 1'b0, 3, 1);
    ns_txn("ns.lh3", 3'b001, 32'h3, 1'b1, 2, 0);

    // Preload words 16/17, then reset during the high half of a split store
    check_txn("pre.w16", 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
    check_txn("pre.w17", 1'b1, 3'b010, 32'h44, 32'h0BAD_1DEA);
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h41; req_wdata = 32'hA5B6_C7D8;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rmid.acc_hi_en", {31'h0, dmem_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rmid.dmem_en", {31'h0, dmem_en}, 32'h0);
    check("rmid.dmem_we", {28'h0, dmem_we}, 32'h0);
    check("rmid.dmem_addr", dmem_addr, 32'h0);
    check("rmid.dmem_d", dmem_d, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmid.no_resp", {31'h0, resp_valid}, 32'h0);
    end
    rst_n = 1'b1;
    // Low part (bytes 0x41..0x43) was written before the reset, high part not
    ref_b[16'h41] = 8'hD8; ref_b[16'h42] = 8'hC7; ref_b[16'h43] = 8'hB6;
    check_txn("rmid.lw44", 1'b0, 3'b010, 32'h44, 32'h0);
    check("rmid.hi_untouched", got_rdata, 32'h0BAD_1DEA);
    check_txn("rmid.lw40", 1'b0, 3'b010, 32'h40, 32'h0);

    // Randomized traffic
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = f3_tab[$urandom_range(0, 4)];
      case ($urandom_range(0, 19))
        0:       addr = $urandom;
        1, 2:    addr = 32'h3FF8 + 32'($urandom_range(0, 7));
        default: addr = 32'($urandom_range(0, 127));
      endcase
      check_txn("rnd", st, f3, addr, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
